// File: rtl/if_id_skid.sv
// ----------------------------------------------------------------------------
// if_id_skid
// IF/ID pipeline boundary register with a two-entry (main + skid) buffer.
// Captures the fetched PC and instruction word, precomputes PC+4, and presents
// the oldest held entry to decode. When decode stalls, one extra word is
// parked in the skid entry and IF is back-pressured one cycle later, so no
// word is ever lost or duplicated. A flush turns all held entries into
// bubbles, and decode-starved cycles are counted in a saturating counter.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   if_valid    IF presents a fetched word
//   if_ready    buffer can accept a word (registered)
//   if_PCadr    PC of the fetched word
//   if_instr    fetched instruction word
//   flush       discard every held entry and this cycle's input
//   id_ready    decode accepts the presented entry (low = stall)
//   id_valid    a real instruction is presented to decode
//   id_PCadr    PC of the presented instruction
//   id_PCplus4  id_PCadr + 4
//   id_instr    presented instruction, NOP_INSTR when id_valid is low
//   bubble_cnt  saturating count of cycles with id_ready & ~id_valid
// ----------------------------------------------------------------------------
module if_id_skid #(
    parameter int             S         = 32,
    parameter logic [S-1:0]   NOP_INSTR = 32'h00000000,
    parameter int             CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [S-1:0]  if_PCadr,
    input  logic [S-1:0]  if_instr,
    input  logic          flush,
    input  logic          id_ready,
    output logic          id_valid,
    output logic [S-1:0]  id_PCadr,
    output logic [S-1:0]  id_PCplus4,
    output logic [S-1:0]  id_instr,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [S-1:0]  PC_STEP = S'(32'd4);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

    // main entry (presented to decode) and skid entry (overflow while stalled)
    logic          m_valid_r;
    logic [S-1:0]  m_pc_r;
    logic [S-1:0]  m_pc4_r;
    logic [S-1:0]  m_instr_r;
    logic          s_valid_r;
    logic [S-1:0]  s_pc_r;
    logic [S-1:0]  s_pc4_r;
    logic [S-1:0]  s_instr_r;
    logic          if_ready_r;
    logic [S-1:0]  id_instr_r;
    logic [CW-1:0] bubble_cnt_r;

    logic          in_fire_s;
    logic          out_fire_s;
    logic [S-1:0]  in_pc4_s;
    logic          m_valid_nxt_s;
    logic [S-1:0]  m_pc_nxt_s;
    logic [S-1:0]  m_pc4_nxt_s;
    logic [S-1:0]  m_instr_nxt_s;
    logic          s_valid_nxt_s;
    logic [S-1:0]  s_pc_nxt_s;
    logic [S-1:0]  s_pc4_nxt_s;
    logic [S-1:0]  s_instr_nxt_s;
    logic          if_ready_nxt_s;
    logic [S-1:0]  id_instr_nxt_s;
    logic [CW-1:0] bubble_cnt_nxt_s;

    assign in_fire_s  = if_valid & if_ready_r;
    assign out_fire_s = m_valid_r & id_ready;
    assign in_pc4_s   = if_PCadr + PC_STEP;

    // Next-state for both entries, the ready flag, the bubble-muxed instruction and the counter
    always_comb begin
        m_valid_nxt_s    = m_valid_r;
        m_pc_nxt_s       = m_pc_r;
        m_pc4_nxt_s      = m_pc4_r;
        m_instr_nxt_s    = m_instr_r;
        s_valid_nxt_s    = s_valid_r;
        s_pc_nxt_s       = s_pc_r;
        s_pc4_nxt_s      = s_pc4_r;
        s_instr_nxt_s    = s_instr_r;
        bubble_cnt_nxt_s = bubble_cnt_r;

        if (flush) begin
            // Payload fields are left as-is; the cleared valid bits make them bubbles.
            m_valid_nxt_s = 1'b0;
            s_valid_nxt_s = 1'b0;
        end else if (!m_valid_r) begin
            if (in_fire_s) begin
                m_valid_nxt_s = 1'b1;
                m_pc_nxt_s    = if_PCadr;
                m_pc4_nxt_s   = in_pc4_s;
                m_instr_nxt_s = if_instr;
            end else begin
                m_valid_nxt_s = 1'b0;
            end
        end else if (out_fire_s) begin
            if (s_valid_r) begin
                // if_ready was low, so nothing can arrive this cycle.
                m_pc_nxt_s    = s_pc_r;
                m_pc4_nxt_s   = s_pc4_r;
                m_instr_nxt_s = s_instr_r;
                s_valid_nxt_s = 1'b0;
            end else if (in_fire_s) begin
                m_pc_nxt_s    = if_PCadr;
                m_pc4_nxt_s   = in_pc4_s;
                m_instr_nxt_s = if_instr;
            end else begin
                m_valid_nxt_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                // Skid is known empty here because if_ready was high.
                s_valid_nxt_s = 1'b1;
                s_pc_nxt_s    = if_PCadr;
                s_pc4_nxt_s   = in_pc4_s;
                s_instr_nxt_s = if_instr;
            end else begin
                s_valid_nxt_s = s_valid_r;
            end
        end

        // Ready is the registered inverse of skid occupancy: back-pressure lags one cycle.
        if_ready_nxt_s = ~s_valid_nxt_s;

        if (m_valid_nxt_s) begin
            id_instr_nxt_s = m_instr_nxt_s;
        end else begin
            id_instr_nxt_s = NOP_INSTR;
        end

        if (id_ready && !m_valid_r && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_nxt_s = bubble_cnt_r + CNT_ONE;
        end else begin
            bubble_cnt_nxt_s = bubble_cnt_r;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_r    <= 1'b0;
            m_pc_r       <= '0;
            m_pc4_r      <= '0;
            m_instr_r    <= '0;
            s_valid_r    <= 1'b0;
            s_pc_r       <= '0;
            s_pc4_r      <= '0;
            s_instr_r    <= '0;
            if_ready_r   <= 1'b1;
            id_instr_r   <= NOP_INSTR;
            bubble_cnt_r <= '0;
        end else begin
            m_valid_r    <= m_valid_nxt_s;
            m_pc_r       <= m_pc_nxt_s;
            m_pc4_r      <= m_pc4_nxt_s;
            m_instr_r    <= m_instr_nxt_s;
            s_valid_r    <= s_valid_nxt_s;
            s_pc_r       <= s_pc_nxt_s;
            s_pc4_r      <= s_pc4_nxt_s;
            s_instr_r    <= s_instr_nxt_s;
            if_ready_r   <= if_ready_nxt_s;
            id_instr_r   <= id_instr_nxt_s;
            bubble_cnt_r <= bubble_cnt_nxt_s;
        end
    end

    assign if_ready   = if_ready_r;
    assign id_valid   = m_valid_r;
    assign id_PCadr   = m_pc_r;
    assign id_PCplus4 = m_pc4_r;
    assign id_instr   = id_instr_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_if_id_skid.sv
// ----------------------------------------------------------------------------
// tb_if_id_skid
// Directed testbench for if_id_skid with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// that same point, i.e. they show the state registered by the preceding edge.
// The counter width is set to 4 so saturation is reachable quickly.
// ----------------------------------------------------------------------------
module tb_if_id_skid;

    localparam int          S   = 32;
    localparam int          CW  = 4;
    localparam logic [31:0] NOP = 32'h00000000;

    logic          clk;
    logic          reset;
    logic          if_valid;
    logic          if_ready;
    logic [S-1:0]  if_PCadr;
    logic [S-1:0]  if_instr;
    logic          flush;
    logic          id_ready;
    logic          id_valid;
    logic [S-1:0]  id_PCadr;
    logic [S-1:0]  id_PCplus4;
    logic [S-1:0]  id_instr;
    logic [CW-1:0] bubble_cnt;

    int n_checks;
    int n_errors;

    if_id_skid #(.S(S), .NOP_INSTR(NOP), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_PCadr   (if_PCadr),
        .if_instr   (if_instr),
        .flush      (flush),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_PCadr   (id_PCadr),
        .id_PCplus4 (id_PCplus4),
        .id_instr   (id_instr),
        .bubble_cnt (bubble_cnt)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        if_valid = v;
        if_PCadr = pc;
        if_instr = ins;
    endtask

    // Check the whole decode-side view of the main entry
    task automatic check_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check_val({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
        if (v) begin
            check_val({tag, ".pc"},  id_PCadr,   pc);
            check_val({tag, ".pc4"}, id_PCplus4, pc + 32'd4);
            check_val({tag, ".ins"}, id_instr,   ins);
        end else begin
            check_val({tag, ".ins"}, id_instr, NOP);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);

        // Reset state
        tick(); tick(); tick();
        check_val("rst.valid",  {31'd0, id_valid}, 32'd0);
        check_val("rst.ready",  {31'd0, if_ready}, 32'd1);
        check_val("rst.pc",     id_PCadr,   32'h0);
        check_val("rst.pc4",    id_PCplus4, 32'h0);
        check_val("rst.ins",    id_instr,   NOP);
        check_val("rst.bubble", {28'd0, bubble_cnt}, 32'd0);

        // Bubble counting from reset: 5 starved cycles, then saturation at 15
        reset    = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("bub.five", {28'd0, bubble_cnt}, 32'd5);
        for (int i = 0; i < 15; i++) tick();
        check_val("bub.sat", {28'd0, bubble_cnt}, 32'd15);
        tick();
        check_val("bub.hold", {28'd0, bubble_cnt}, 32'd15);
        // A stalled decode with no instruction does not count; reset clears the counter
        reset = 1'b0;
        #1;
        check_val("bub.rstclr", {28'd0, bubble_cnt}, 32'd0);
        tick();
        reset    = 1'b1;
        id_ready = 1'b0;
        tick(); tick();
        check_val("bub.stall0", {28'd0, bubble_cnt}, 32'd0);

        // Test 1: streaming at full throughput
        id_ready = 1'b1;
        offer(1'b1, 32'h0, 32'h20080001);
        tick();
        check_id("t1.w0", 1'b1, 32'h0, 32'h20080001);
        check_val("t1.rdy0", {31'd0, if_ready}, 32'd1);
        offer(1'b1, 32'h4, 32'h20080002);
        tick();
        check_id("t1.w1", 1'b1, 32'h4, 32'h20080002);
        check_val("t1.rdy1", {31'd0, if_ready}, 32'd1);
        offer(1'b1, 32'h8, 32'h20080003);
        tick();
        check_id("t1.w2", 1'b1, 32'h8, 32'h20080003);
        check_val("t1.rdy2", {31'd0, if_ready}, 32'd1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        check_id("t1.drain", 1'b0, 32'h0, 32'h0);

        // Test 2: decode stall fills main then skid, back-pressure one cycle late
        id_ready = 1'b0;
        offer(1'b1, 32'h100, 32'hA0000100);
        tick();
        check_id("t2.e1", 1'b1, 32'h100, 32'hA0000100);
        check_val("t2.rdy1", {31'd0, if_ready}, 32'd1);
        offer(1'b1, 32'h104, 32'hA0000104);
        tick();
        check_id("t2.e2", 1'b1, 32'h100, 32'hA0000100);
        check_val("t2.rdy2", {31'd0, if_ready}, 32'd0);
        offer(1'b1, 32'h108, 32'hA0000108);
        tick();
        check_id("t2.e3", 1'b1, 32'h100, 32'hA0000100);
        check_val("t2.rdy3", {31'd0, if_ready}, 32'd0);
        id_ready = 1'b1;
        tick();
        check_id("t2.e4", 1'b1, 32'h104, 32'hA0000104);
        check_val("t2.rdy4", {31'd0, if_ready}, 32'd1);
        tick();
        check_id("t2.e5", 1'b1, 32'h108, 32'hA0000108);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        check_id("t2.e6", 1'b0, 32'h0, 32'h0);

        // Test 3a: flush with both entries full while IF offers 0x200
        id_ready = 1'b0;
        offer(1'b1, 32'h300, 32'hB0000300);
        tick();
        offer(1'b1, 32'h304, 32'hB0000304);
        tick();
        check_val("t3.full", {31'd0, if_ready}, 32'd0);
        offer(1'b1, 32'h200, 32'hC0000200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_id("t3.fl", 1'b0, 32'h0, 32'h0);
        check_val("t3.rdy", {31'd0, if_ready}, 32'd1);
        offer(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        tick();
        check_id("t3.after", 1'b0, 32'h0, 32'h0);

        // Test 3b: flush while ready, the word offered that cycle is discarded
        id_ready = 1'b0;
        offer(1'b1, 32'h310, 32'hB0000310);
        tick();
        check_id("t3b.main", 1'b1, 32'h310, 32'hB0000310);
        offer(1'b1, 32'h204, 32'hC0000204);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_id("t3b.fl", 1'b0, 32'h0, 32'h0);
        check_val("t3b.rdy", {31'd0, if_ready}, 32'd1);
        offer(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        tick();
        check_id("t3b.after", 1'b0, 32'h0, 32'h0);

        // Test 4: PC+4 wraps modulo 2^32
        offer(1'b1, 32'hFFFFFFFC, 32'h12345678);
        tick();
        check_val("t4.valid", {31'd0, id_valid}, 32'd1);
        check_val("t4.pc",    id_PCadr,   32'hFFFFFFFC);
        check_val("t4.pc4",   id_PCplus4, 32'h00000000);
        check_val("t4.ins",   id_instr,   32'h12345678);
        offer(1'b0, 32'h0, 32'h0);
        tick();

        // Test 6: asynchronous reset while two entries are held
        id_ready = 1'b0;
        offer(1'b1, 32'h400, 32'hD0000400);
        tick();
        offer(1'b1, 32'h404, 32'hD0000404);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check_val("t6.pre", {31'd0, if_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_val("t6.valid",  {31'd0, id_valid}, 32'd0);
        check_val("t6.ready",  {31'd0, if_ready}, 32'd1);
        check_val("t6.pc",     id_PCadr,   32'h0);
        check_val("t6.pc4",    id_PCplus4, 32'h0);
        check_val("t6.ins",    id_instr,   NOP);
        check_val("t6.bubble", {28'd0, bubble_cnt}, 32'd0);
        tick();
        reset    = 1'b1;
        id_ready = 1'b1;
        tick();
        check_id("t6.rel1", 1'b0, 32'h0, 32'h0);
        tick();
        check_id("t6.rel2", 1'b0, 32'h0, 32'h0);
        check_val("t6.bub", {28'd0, bubble_cnt}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Pipeline boundary register between instruction fetch (IF) and decode (ID) in the 32-bit MIPS pipeline.
- Captures the fetched PC and instruction word and presents them to the decode stage, which in turn feeds the ID/EX register.
- A two-entry skid buffer (main plus skid) provides full-throughput valid/ready decoupling. When decode stalls, IF is back-pressured one cycle late and no word is lost.
- Supports a branch/jump flush that turns all held entries into no-op bubbles, and counts decode-starved cycles for performance analysis.

Parameters:
- S, 32, data width of PC and instruction.
- NOP_INSTR, 32'h00000000, instruction word presented to decode when no valid entry is held (sll $0,$0,0).
- CW, 16, width of the bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- if_valid  input  1  IF presents a fetched word this cycle.
- if_ready  output  1  buffer can accept a word this cycle; registered.
- if_PCadr  input  S  PC of the fetched instruction.
- if_instr  input  S  fetched instruction word.
- flush  input  1  discard all held entries and this cycle's input.
- id_ready  input  1  decode accepts the presented entry this cycle; low means stall.
- id_valid  output  1  a real instruction is presented to decode.
- id_PCadr  output  S  PC of the presented instruction.
- id_PCplus4  output  S  id_PCadr+4, registered.
- id_instr  output  S  presented instruction word, or NOP_INSTR when id_valid==0.
- bubble_cnt  output  CW  count of cycles with id_ready==1 and id_valid==0; saturates.

Behaviour:
- State: main entry {m_valid, m_pc, m_pc4, m_instr} and skid entry {s_valid, s_pc, s_pc4, s_instr}.
- Outputs: id_valid=m_valid; id_PCadr, id_PCplus4 and id_instr come from main.
- Reset (reset==0, asynchronous):
  - m_valid=0, s_valid=0; pc, pc4 and instr fields of both entries = 0.
  - if_ready=1, bubble_cnt=0.
  - id_valid=0, id_PCadr=0, id_PCplus4=0, id_instr=NOP_INSTR.
  - Reset asserted mid-operation drops everything at once. The first accept after release occurs on the first rising edge with reset==1.
- Bubble output: id_instr=NOP_INSTR whenever m_valid==0, regardless of m_instr.
- Events per rising edge:
  - in_fire = if_valid & if_ready.
  - out_fire = m_valid & id_ready.
- Flush has priority over everything:
  - m_valid<=0, s_valid<=0, if_ready<=1.
  - The in_fire word of that same cycle is discarded.
  - bubble_cnt still updates normally.
- Otherwise, next-state transitions:
  - Main empty, in_fire: main<=input.
  - Main full, out_fire, skid full: main<=skid, s_valid<=0. Skid full implies if_ready==0, so no in_fire.
  - Main full, out_fire, skid empty, in_fire: main<=input.
  - Main full, out_fire, skid empty, no in_fire: m_valid<=0.
  - Main full, no out_fire, in_fire: skid<=input, s_valid<=1. Skid empty is guaranteed because if_ready==1.
  - Main full, no out_fire, no in_fire: hold.
- if_ready<=~next_s_valid. A word accepted into skid drops if_ready on the following cycle.
- Latency: one cycle, input edge to id_valid. Sustained throughput is 1 word/cycle with id_ready held high.
- pc4 is computed on capture as pc+4, modulo 2^S. PC 32'hFFFFFFFC gives 32'h00000000.
- Ordering: entries leave in arrival order, with no loss and no duplication.
- bubble_cnt increments when id_ready & ~m_valid and the count is below 2^CW−1. It saturates at all-ones and is cleared only by reset.
- if_valid is ignored when if_ready==0. IF must hold its word until accepted; an unaccepted word is not stored.

Test Plan:
1. Reset mid-stream, then release; stream PCs 0x0,0x4,0x8 with instrs 0x20080001..03 and id_ready=1 -> id_valid rises 1 cycle after the first accept; outputs match in order; id_PCplus4=0x4,0x8,0xC; if_ready stays 1.
2. Stall: id_ready=0 for 3 cycles while IF offers 0x100,0x104,0x108 -> 0x100 held in main, 0x104 in skid, if_ready=0 from the next cycle, 0x108 not accepted until id_ready returns; order after release is 0x100,0x104,0x108.
3. Flush with both entries full and if_valid=1 (PC 0x200) -> next cycle id_valid=0, id_instr=NOP_INSTR, if_ready=1; 0x200 never appears at id.
4. if_PCadr=0xFFFFFFFC -> id_PCplus4=0x00000000.
5. id_ready=1, if_valid=0 for 5 cycles from reset -> bubble_cnt=5; with CW=4 and 20 such cycles, bubble_cnt saturates at 15.
6. Assert reset while a stall is holding two entries -> outputs clear immediately without a clock edge; no pre-reset word emerges after release.
